serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Multi-cycle bit-serial subtractor that computes DIFF = A - B - Bin one bit per clock, LSB first, using a ripple-borrow cell. It is the inverse-direction companion to the team's ripple-carry adder datapath and shares its operand and flag conventions. Use it where area matters more than latency. Control is a start/busy/done handshake so a sequencer can issue subtractions back-to-back.

Parameters:
WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  minuend; captured on the accepting edge
b  input  WIDTH  subtrahend; captured on the accepting edge
bin  input  1  borrow-in; captured on the accepting edge
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when the result is valid
diff  output  WIDTH  result A - B - Bin, modulo 2^WIDTH
bout  output  1  borrow-out; 1 when unsigned A < B + Bin
ovf  output  1  signed two's-complement overflow of the subtraction

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; internal operand regs, bit index and borrow cleared. Reset mid-operation abandons the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE/DONE -> RUN on any edge with start=1. That edge (t0) latches a, b and bin into the working registers, sets bit index=0 and borrow=bin.
- RUN: each edge t1..tW processes bit i=index:
  - d_i = a_i ^ b_i ^ br
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d_i shifts into the result shift register; index increments.
- The edge that processes bit WIDTH-1 (tW) moves RUN -> DONE and updates the outputs in the same edge:
  - diff = full result
  - bout = final borrow
  - ovf = (a_msb != b_msb) & (d_msb != a_msb)
- busy=1 exactly while state=RUN, i.e. after t0 through tW, for WIDTH cycles.
- done=1 exactly while state=DONE, for one cycle after tW. Latency from the start edge to done high is WIDTH+1 edges.
- DONE -> IDLE on the next edge if start=0. DONE -> RUN if start=1; this gives back-to-back operation and done stays low in the new RUN.
- start while busy=1 is ignored. Operand changes on a/b/bin during RUN have no effect.
- diff, bout and ovf change only at the completing edge and hold their values until the next completion or reset. Partial results are never visible.
- The bit index counter is ceil(log2(WIDTH)) bits wide and never wraps past WIDTH-1.
- bin=1 with a=b produces diff of all ones and bout=1.

Test Plan:
- WIDTH=4, a=7, b=3, bin=0, start pulse at t0 -> busy high 4 cycles; done pulse after t4; diff=4, bout=0, ovf=0.
- a=3, b=7, bin=0 -> diff=0xC, bout=1, ovf=0; after done returns low, outputs still hold 0xC/1/0.
- a=8 (-8), b=1, bin=0 -> diff=0x7, bout=0, ovf=1. Then a=0, b=0, bin=1 -> diff=0xF, bout=1, ovf=0.
- start re-asserted at t2 with a=0xF, b=0 during RUN of 7-3 -> ignored; diff=4 at done; no extra busy cycles.
- start held high in the DONE cycle with a=5, b=5, bin=0 -> immediate new RUN, done low for 4 cycles, then diff=0, bout=0.
- rst_n pulled low asynchronously at t2 of 7-3 (previous diff=0xC) -> busy, done, diff, bout and ovf go 0 immediately; no done pulse after release; next start works normally.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - Bin, one bit per clock, LSB first.
// A start/busy/done handshake lets a sequencer chain operations back-to-back.
// The result, borrow-out and overflow registers update only on the completing
// edge, so partial results are never visible on the outputs.

// One ripple-borrow cell: single-bit full subtractor.
module serial_sub_cell (
  input  logic a,
  input  logic b,
  input  logic br_in,
  output logic d,
  output logic br_out
);
  // Difference and borrow for one bit position.
  always_comb begin
    d      = a ^ b ^ br_in;
    br_out = (~a & b) | (~(a ^ b) & br_in);
  end
endmodule

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa, opb;   // operands frozen at the accepting edge
  logic [WIDTH-1:0] sr;         // result shift register, fills from the MSB end
  logic [IW-1:0]    idx;        // bit currently being processed
  logic             br;         // running borrow

  logic a_bit, b_bit, d_bit, br_nxt, last;
  logic [WIDTH-1:0] sr_nxt;

  // Select the current operand bits and form the shifted result.
  always_comb begin
    a_bit  = opa[idx];
    b_bit  = opb[idx];
    last   = (idx == LAST_IDX);
    sr_nxt = {d_bit, sr[WIDTH-1:1]};
  end

  serial_sub_cell u_cell (
    .a      (a_bit),
    .b      (b_bit),
    .br_in  (br),
    .d      (d_bit),
    .br_out (br_nxt)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      sr    <= '0;
      idx   <= '0;
      br    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            opb   <= b;
            br    <= bin;
            idx   <= '0;
            sr    <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sr <= sr_nxt;
          br <= br_nxt;
          if (last) begin
            // Index parks at the last bit rather than wrapping.
            diff  <= sr_nxt;
            bout  <= br_nxt;
            ovf   <= (opa[WIDTH-1] != opb[WIDTH-1]) & (d_bit != opa[WIDTH-1]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): stimulus pushes expected
// results, a negedge monitor pops and compares whenever done is high.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout, ovf;
  logic [W-1:0] diff;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_exp;
  int tests = 0;
  int fails = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got diff=0x%0h with no request pending", diff);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("result{diff,bout,ovf}", {diff, bout, ovf}, e);
      end
    end
  end

  // Present a request at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       input logic [W-1:0] ed, input logic eb, input logic eo, input bit push);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    if (push) begin
      exp_q.push_back({ed, eb, eo});
      last_exp = {ed, eb, eo};
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done, counting busy cycles; optionally inject a start at t2.
  task automatic wait_done(input string name, input bit inject, input bit hold_chk);
    int cycles = 0;
    int busy_cnt = 0;
    while (done !== 1'b1 && cycles < 50) begin
      if (busy === 1'b1) busy_cnt++;
      if (inject && cycles == 1) begin
        a = 4'hF; b = 4'h0; bin = 1'b0; start = 1'b1;
      end
      if (inject && cycles == 2) start = 1'b0;
      cycles++;
      @(negedge clk);
    end
    check({name, "_latency"}, cycles, W);
    check({name, "_busy_cycles"}, busy_cnt, W);
    if (hold_chk) begin
      @(negedge clk);
      check({name, "_done_pulse_width"}, {busy, done}, 2'b00);
      check({name, "_hold"}, {diff, bout, ovf}, last_exp);
    end
  endtask

  initial begin
    // Reset state.
    #12;
    check("reset_outputs", {busy, done, diff, bout, ovf}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(4'h7, 4'h3, 1'b0, 4'h4, 1'b0, 1'b0, 1);
    wait_done("7-3", 0, 1);
    issue(4'h3, 4'h7, 1'b0, 4'hC, 1'b1, 1'b0, 1);
    wait_done("3-7", 0, 1);
    repeat (2) @(negedge clk);
    check("hold_after_idle", {diff, bout, ovf}, {4'hC, 1'b1, 1'b0});
    issue(4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1, 1);
    wait_done("-8-1", 0, 1);
    issue(4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1);
    wait_done("0-0-1", 0, 1);
    issue(4'h7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1, 1);
    wait_done("7-(-1)", 0, 1);
    issue(4'h9, 4'h9, 1'b1, 4'hF, 1'b1, 1'b0, 1);
    wait_done("9-9-1", 0, 1);

    // Start during RUN is ignored.
    issue(4'h7, 4'h3, 1'b0, 4'h4, 1'b0, 1'b0, 1);
    wait_done("ignored_start", 1, 1);

    // Back-to-back: start held in the DONE cycle.
    issue(4'h7, 4'h3, 1'b0, 4'h4, 1'b0, 1'b0, 1);
    wait_done("b2b_first", 0, 0);
    issue(4'h5, 4'h5, 1'b0, 4'h0, 1'b0, 1'b0, 1);
    wait_done("b2b_second", 0, 1);

    // Asynchronous reset mid-operation.
    issue(4'h3, 4'h7, 1'b0, 4'hC, 1'b1, 1'b0, 1);
    wait_done("pre_reset", 0, 1);
    issue(4'h7, 4'h3, 1'b0, 4'h0, 1'b0, 1'b0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {busy, done, diff, bout, ovf}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("no_done_after_reset", {busy, done, diff}, '0);
    issue(4'h6, 4'h2, 1'b1, 4'h3, 1'b0, 1'b0, 1);
    wait_done("post_reset", 0, 1);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
